// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith ops plus bit-serial
// multiply and restoring divide sharing one 2*XLEN shift register.
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready on
  // that side; in_ready is combinational so a new op can issue on the same
  // edge the previous result is consumed.

  typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW-1:0]  LAST     = SHW'(XLEN - 1);

  state_t              state;
  logic [3:0]          op_r;
  logic [XLEN-1:0]     opb;
  logic [2*XLEN-1:0]   prod;
  logic [SHW-1:0]      cnt;
  logic                neg_q;
  logic                neg_r;

  logic                slot_free;
  logic                accept;
  logic [SHW-1:0]      sh;
  logic                b_zero;
  logic                div_ovf;
  logic                sgn_op;
  logic                a_neg;
  logic                b_neg;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  logic                is_fast;
  logic [XLEN-1:0]     fast_val;
  logic [XLEN:0]       mul_acc;
  logic [XLEN:0]       div_trial;
  logic [XLEN-1:0]     hold_val;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);

  assign sh      = src_b[SHW-1:0];
  assign b_zero  = (src_b == '0);
  assign sgn_op  = (alu_control == 4'd12) || (alu_control == 4'd14);
  assign div_ovf = sgn_op && (src_a == MOST_NEG) && (src_b == '1);
  assign a_neg   = sgn_op && src_a[XLEN-1];
  assign b_neg   = sgn_op && src_b[XLEN-1];
  assign a_mag   = a_neg ? -src_a : src_a;
  assign b_mag   = b_neg ? -src_b : src_b;

  always_comb begin
    fast_val = '0;
    is_fast  = 1'b1;
    case (alu_control)
      4'd0:  fast_val = src_a & src_b;
      4'd1:  fast_val = src_a | src_b;
      4'd2:  fast_val = src_a + src_b;
      4'd3:  fast_val = src_a ^ src_b;
      4'd4:  fast_val = src_a << sh;
      4'd5:  fast_val = src_a >> sh;
      4'd6:  fast_val = src_a - src_b;
      4'd7:  fast_val = $signed(src_a) >>> sh;
      4'd8:  fast_val = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'd9:  fast_val = {{(XLEN-1){1'b0}}, src_a < src_b};
      4'd12: begin
        if (b_zero)       fast_val = '1;
        else if (div_ovf) fast_val = src_a;
        else              is_fast  = 1'b0;
      end
      4'd13: begin
        if (b_zero) fast_val = '1;
        else        is_fast  = 1'b0;
      end
      4'd14: begin
        if (b_zero)       fast_val = src_a;
        else if (div_ovf) fast_val = '0;
        else              is_fast  = 1'b0;
      end
      4'd15: begin
        if (b_zero) fast_val = src_a;
        else        is_fast  = 1'b0;
      end
      default: is_fast = 1'b0;
    endcase
  end

  // prod holds {partial_product, multiplier} for MUL and {remainder, quotient}
  // for DIV; opb holds the multiplicand or divisor magnitude.
  assign mul_acc   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? opb : {XLEN{1'b0}})};
  assign div_trial = prod[2*XLEN-1:XLEN-1] - {1'b0, opb};

  always_comb begin
    hold_val = '0;
    case (op_r)
      4'd10:        hold_val = prod[XLEN-1:0];
      4'd11:        hold_val = prod[2*XLEN-1:XLEN];
      4'd12, 4'd13: hold_val = neg_q ? -prod[XLEN-1:0] : prod[XLEN-1:0];
      default:      hold_val = neg_r ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      op_r      <= '0;
      opb       <= '0;
      prod      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      // A load below overrides this drain on the same edge.
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_r <= alu_control;
            cnt  <= '0;
            if (is_fast) begin
              result    <= fast_val;
              zero      <= (fast_val == '0);
              out_valid <= 1'b1;
            end else if (alu_control[3:1] == 3'b101) begin
              opb   <= src_a;
              prod  <= {{XLEN{1'b0}}, src_b};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= MUL;
            end else begin
              opb   <= b_mag;
              prod  <= {{XLEN{1'b0}}, a_mag};
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= DIV;
            end
          end
        end
        MUL: begin
          prod <= {mul_acc, prod[XLEN-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= HOLD;
        end
        DIV: begin
          if (!div_trial[XLEN]) prod <= {div_trial[XLEN-1:0], prod[XLEN-2:0], 1'b1};
          else                  prod <= {prod[2*XLEN-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= HOLD;
        end
        HOLD: begin
          if (slot_free) begin
            result    <= hold_val;
            zero      <= (hold_val == '0);
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, hand-written multi-cycle corner
// sequences, and randomized traffic against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_control = '0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  logic         rand_bp = 1'b0;
  logic         rnd_or = 1'b1;
  logic         or_dir = 1'b1;
  assign out_ready = rand_bp ? rnd_or : or_dir;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           xfer_cyc[$];

  alu_seq #(.XLEN(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1 rnd_or = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = longint'(a);
    longint unsigned ub = longint'(b);
    longint unsigned p  = ua * ub;
    int              s  = int'(b % W);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return a << s;
      4'd5:  return a >> s;
      4'd6:  return a - b;
      4'd7:  return W'(sa >>> s);
      4'd8:  return (sa < sb) ? 1 : 0;
      4'd9:  return (ua < ub) ? 1 : 0;
      4'd10: return p[W-1:0];
      4'd11: return p[2*W-1:W];
      4'd12: return (b == 0) ? '1 : W'(sa / sb);
      4'd13: return (b == 0) ? '1 : W'(ua / ub);
      4'd14: return (b == 0) ? a : W'(sa % sb);
      default: return (b == 0) ? a : W'(ua % ub);
    endcase
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard: expectations enter on input transfers, leave on output transfers.
  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_res = '0;
  logic         prev_zero = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", W'(out_valid), W'(1));
        chk("stall_result", result, prev_res);
        chk("stall_zero", W'(zero), W'(prev_zero));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", W'(1), W'(0));
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("sb_result", result, e);
          chk("sb_zero", W'(zero), W'(e == '0));
        end
        got_q.push_back(result);
        xfer_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_alu(alu_control, src_a, src_b));
      stall_prev = out_valid && !out_ready;
      prev_res   = result;
      prev_zero  = zero;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    waited = 0;
    in_valid = 1'b1;
    alu_control = op;
    src_a = a;
    src_b = b;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", W'(0), W'(1));
    sync();
    in_valid = 1'b0;
    alu_control = 4'($urandom);
    src_a = W'($urandom);
    src_b = W'($urandom);
  endtask

  task automatic wait_valid(output int lat, output int busy_n, output int rdy_bad);
    lat = 1;
    busy_n = 0;
    rdy_bad = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      if (in_ready) rdy_bad++;
      lat++;
      @(negedge clk);
    end
    if (!out_valid) chk("valid_timeout", W'(0), W'(1));
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int w, lat, bn, rb;
    logic [W-1:0] ra, rbv;

    vecs.push_back('{4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1,  "add_wrap"});
    vecs.push_back('{4'd6,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1,  "sub_zero"});
    vecs.push_back('{4'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1,  "and"});
    vecs.push_back('{4'd1,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1,  "or"});
    vecs.push_back('{4'd4,  32'h0000_0003, 32'h0000_0023, 32'h0000_0018, 1,  "sll_lowbits"});
    vecs.push_back('{4'd5,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1,  "srl_lowbits"});
    vecs.push_back('{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1,  "slt"});
    vecs.push_back('{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1,  "sltu"});
    vecs.push_back('{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34, "mul"});
    vecs.push_back('{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu"});
    vecs.push_back('{4'd12, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, "div_neg"});
    vecs.push_back('{4'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, "rem_neg"});
    vecs.push_back('{4'd13, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1,  "divu_by0"});
    vecs.push_back('{4'd15, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1,  "remu_by0"});
    vecs.push_back('{4'd12, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1,  "div_by0"});
    vecs.push_back('{4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf"});
    vecs.push_back('{4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf"});
    vecs.push_back('{4'd13, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 34, "divu"});
    vecs.push_back('{4'd15, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 34, "remu"});

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", result, W'(0));
    chk("rst_zero", W'(zero), W'(1));
    chk("rst_busy", W'(busy), W'(0));
    rst_n = 1'b1;
    sync();
    chk("post_rst_in_ready", W'(in_ready), W'(1));

    // Vector table with latency and busy checks.
    or_dir = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, w);
      wait_valid(lat, bn, rb);
      chk({vecs[i].name, "_result"}, result, vecs[i].exp);
      chk({vecs[i].name, "_zero"}, W'(zero), W'(vecs[i].exp == '0));
      chk({vecs[i].name, "_latency"}, W'(lat), W'(vecs[i].lat));
      chk({vecs[i].name, "_busy_cycles"}, W'(bn), W'(vecs[i].lat - 1));
      chk({vecs[i].name, "_in_ready_low"}, W'(rb), W'(0));
      sync();
    end

    // Back-to-back single-cycle issue while results drain.
    got_q.delete();
    xfer_cyc.delete();
    send(4'd2, 32'h1234_5678, 32'h1111_1111, w);
    chk("b2b_add_wait", W'(w), W'(0));
    send(4'd3, 32'hFF00_FF00, 32'h0F0F_0F0F, w);
    chk("b2b_xor_wait", W'(w), W'(0));
    send(4'd7, 32'h8000_0000, 32'h0000_0004, w);
    chk("b2b_sra_wait", W'(w), W'(0));
    send(4'd9, 32'h0000_0001, 32'hFFFF_FFFF, w);
    chk("b2b_sltu_wait", W'(w), W'(0));
    repeat (2) @(negedge clk);
    chk("b2b_count", W'(got_q.size()), W'(4));
    if (got_q.size() == 4) begin
      chk("b2b_add", got_q[0], 32'h2345_6789);
      chk("b2b_xor", got_q[1], 32'hF00F_F00F);
      chk("b2b_sra", got_q[2], 32'hF800_0000);
      chk("b2b_sltu", got_q[3], 32'h0000_0001);
      for (int i = 0; i < 3; i++) chk("b2b_spacing", W'(xfer_cyc[i+1] - xfer_cyc[i]), W'(1));
    end

    // Output backpressure after a multi-cycle divide.
    sync();
    or_dir = 1'b0;
    send(4'd13, 32'd100, 32'd7, w);
    wait_valid(lat, bn, rb);
    chk("bp_latency", W'(lat), W'(34));
    chk("bp_busy_cycles", W'(bn), W'(33));
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", W'(out_valid), W'(1));
      chk("bp_result", result, W'(14));
      chk("bp_in_ready", W'(in_ready), W'(0));
      @(negedge clk);
    end
    sync();
    got_q.delete();
    or_dir = 1'b1;
    send(4'd2, 32'd3, 32'd4, w);
    chk("bp_issue_wait", W'(w), W'(0));
    wait_valid(lat, bn, rb);
    chk("bp_next_result", result, W'(7));
    chk("bp_next_latency", W'(lat), W'(1));
    sync();
    @(negedge clk);
    chk("bp_xfer_count", W'(got_q.size()), W'(2));
    if (got_q.size() == 2) chk("bp_xfer_first", got_q[0], W'(14));

    // Reset in the middle of a multiply.
    send(4'd10, W'($urandom), W'($urandom), w);
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_result", result, W'(0));
    chk("abort_zero", W'(zero), W'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sync();
    chk("abort_in_ready", W'(in_ready), W'(1));
    send(4'd2, 32'd40, 32'd2, w);
    wait_valid(lat, bn, rb);
    chk("abort_add_result", result, W'(42));
    chk("abort_add_latency", W'(lat), W'(1));
    sync();

    // Randomized traffic with random output backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 300; n++) begin
      ra = pick_val();
      rbv = pick_val();
      send(4'($urandom_range(0, 15)), ra, rbv, w);
      repeat ($urandom_range(0, 2)) sync();
    end
    rand_bp = 1'b0;
    or_dir = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
